hex_entry: RTL

- Input-side counterpart of the 8-digit seven-segment display path. The display renders a 32-bit word; this block builds that word from operator input.
- Operator input is a 4-bit hex switch bank plus three push-buttons. The block debounces the buttons, shifts hex digits into a 32-bit entry register, and on commit presents the word with a one-cycle load strobe.
- The committed word drives the display data input and the processor's I/O input register.

---
 rtl/hex_entry.sv | 117 +++++++++++
 1 files changed

// File: rtl/hex_entry.sv
// rtl/hex_entry.sv - hex digit entry: key sync/debounce, shift-in entry register, commit strobe
module hex_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sw,
    input  logic        key_enter,
    input  logic        key_clear,
    input  logic        key_commit,
    output logic [31:0] data_out,
    output logic        load,
    output logic [31:0] entry,
    output logic [3:0]  digit_cnt,
    output logic        full
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int K_ENTER  = 0;
    localparam int K_CLEAR  = 1;
    localparam int K_COMMIT = 2;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL_ST
    } state_t;

    logic [3:0]       sw_s1, sw_s2;
    logic [2:0]       key_s1, key_s2;
    logic [2:0]       db, db_d, press;
    logic [CNT_W-1:0] cnt [3];

    state_t           state_q, state_d;
    logic [31:0]      entry_d, data_d;
    logic [3:0]       digit_cnt_d;
    logic             load_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '0;
            key_s2 <= '0;
            db     <= '0;
            db_d   <= '0;
            press  <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            key_s1 <= {key_commit, key_clear, key_enter};
            key_s2 <= key_s1;
            db_d   <= db;
            // Registered rising edge of the debounced level: one pulse per accepted press.
            press  <= db & ~db_d;
            for (int i = 0; i < 3; i++) begin
                if (key_s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= key_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Clear outranks commit, which outranks enter; losers are dropped.
    always_comb begin
        state_d     = state_q;
        entry_d     = entry;
        digit_cnt_d = digit_cnt;
        data_d      = data_out;
        load_d      = 1'b0;
        if (press[K_CLEAR]) begin
            entry_d     = '0;
            digit_cnt_d = '0;
            state_d     = EMPTY;
        end else if (press[K_COMMIT]) begin
            if (state_q != EMPTY) begin
                data_d      = entry;
                load_d      = 1'b1;
                entry_d     = '0;
                digit_cnt_d = '0;
                state_d     = EMPTY;
            end
        end else if (press[K_ENTER]) begin
            if (state_q != FULL_ST) begin
                entry_d     = {entry[27:0], sw_s2};
                digit_cnt_d = digit_cnt + 4'd1;
                state_d     = (digit_cnt == 4'd7) ? FULL_ST : PARTIAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            entry     <= '0;
            digit_cnt <= '0;
            full      <= 1'b0;
            data_out  <= '0;
            load      <= 1'b0;
        end else begin
            state_q   <= state_d;
            entry     <= entry_d;
            digit_cnt <= digit_cnt_d;
            full      <= (digit_cnt_d == 4'd8);
            data_out  <= data_d;
            load      <= load_d;
        end
    end

endmodule
